// File: rtl/calc1.sv
// calc1: four independent two-operand integer calculator ports, each with its own
// request FSM and ALU. Bit 0 is the MSB on every top-level vector.

module calc1_port (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cmd_in,
    input  logic [31:0] data_in,
    output logic [1:0]  resp_out,
    output logic [31:0] data_out
);

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SLL = 4'd5;
    localparam logic [3:0] CMD_SRL = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } alu_res_t;

    // Unsigned ALU; add carry-out and subtract borrow both report an error with zero data.
    function automatic alu_res_t alu(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b);
        alu_res_t    r;
        logic [32:0] sum;
        r.resp = RESP_ERR;
        r.data = 32'd0;
        sum    = {1'b0, a} + {1'b0, b};
        case (cmd)
            CMD_ADD: begin
                if (sum[32]) begin
                    r.resp = RESP_ERR;
                end else begin
                    r.resp = RESP_OK;
                    r.data = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (b > a) begin
                    r.resp = RESP_ERR;
                end else begin
                    r.resp = RESP_OK;
                    r.data = a - b;
                end
            end
            CMD_SLL: begin
                r.resp = RESP_OK;
                r.data = a << b[4:0];
            end
            CMD_SRL: begin
                r.resp = RESP_OK;
                r.data = a >> b[4:0];
            end
            default: begin
                r.resp = RESP_ERR;
                r.data = 32'd0;
            end
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] op1_q, op1_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] data_q, data_d;
    alu_res_t    alu_s;

    assign alu_s = alu(cmd_q, op1_q, data_in);

    // Next-state and response decode; outputs default to zero except on a response cycle.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        resp_d  = RESP_NONE;
        data_d  = 32'd0;
        case (state_q)
            ST_IDLE: begin
                case (cmd_in)
                    CMD_NOP: begin
                        state_d = ST_IDLE;
                    end
                    CMD_ADD, CMD_SUB, CMD_SLL, CMD_SRL: begin
                        cmd_d   = cmd_in;
                        op1_d   = data_in;
                        state_d = ST_OP2;
                    end
                    default: begin
                        resp_d = RESP_ERR;
                        data_d = 32'd0;
                    end
                endcase
            end
            ST_OP2: begin
                // cmd_in is deliberately ignored while the second operand is on the bus
                resp_d  = alu_s.resp;
                data_d  = alu_s.data;
                cmd_d   = CMD_NOP;
                op1_d   = 32'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_NOP;
                op1_d   = 32'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            op1_q   <= 32'd0;
            resp_q  <= RESP_NONE;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
        end
    end

    assign resp_out = resp_q;
    assign data_out = data_q;

endmodule

module calc1 (
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    input  logic        c_clk,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    input  logic [1:7]  reset
);

    logic        rst_s;
    logic [3:0]  cmd_s  [4];
    logic [31:0] din_s  [4];
    logic [1:0]  resp_s [4];
    logic [31:0] dout_s [4];

    // Any reset bit resets the whole block.
    assign rst_s = |reset;

    // Reversed-range buses carry the same numeric value; copy into MSB-high locals.
    assign cmd_s[0] = req1_cmd_in;
    assign cmd_s[1] = req2_cmd_in;
    assign cmd_s[2] = req3_cmd_in;
    assign cmd_s[3] = req4_cmd_in;
    assign din_s[0] = req1_data_in;
    assign din_s[1] = req2_data_in;
    assign din_s[2] = req3_data_in;
    assign din_s[3] = req4_data_in;

    for (genvar p = 0; p < 4; p++) begin : g_port
        calc1_port u_port (
            .clk      (c_clk),
            .rst      (rst_s),
            .cmd_in   (cmd_s[p]),
            .data_in  (din_s[p]),
            .resp_out (resp_s[p]),
            .data_out (dout_s[p])
        );
    end

    assign out_resp1 = resp_s[0];
    assign out_resp2 = resp_s[1];
    assign out_resp3 = resp_s[2];
    assign out_resp4 = resp_s[3];
    assign out_data1 = dout_s[0];
    assign out_data2 = dout_s[1];
    assign out_data3 = dout_s[2];
    assign out_data4 = dout_s[3];

endmodule

// File: tb/tb_calc1.sv
// Directed self-checking bench for calc1: reset, add/sub/shift, invalid commands,
// four-port concurrency and reset abort of an in-flight request.

module tb_calc1;

    logic        c_clk;
    logic [1:7]  reset;
    logic [0:3]  cmd  [1:4];
    logic [0:31] din  [1:4];
    logic [0:31] out_data1, out_data2, out_data3, out_data4;
    logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;

    int total = 0;
    int bad   = 0;

    calc1 dut (
        .out_data1    (out_data1),
        .out_data2    (out_data2),
        .out_data3    (out_data3),
        .out_data4    (out_data4),
        .out_resp1    (out_resp1),
        .out_resp2    (out_resp2),
        .out_resp3    (out_resp3),
        .out_resp4    (out_resp4),
        .c_clk        (c_clk),
        .req1_cmd_in  (cmd[1]),
        .req1_data_in (din[1]),
        .req2_cmd_in  (cmd[2]),
        .req2_data_in (din[2]),
        .req3_cmd_in  (cmd[3]),
        .req3_data_in (din[3]),
        .req4_cmd_in  (cmd[4]),
        .req4_data_in (din[4]),
        .reset        (reset)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] resp_of(input int p);
        case (p)
            1:       resp_of = {30'd0, out_resp1};
            2:       resp_of = {30'd0, out_resp2};
            3:       resp_of = {30'd0, out_resp3};
            default: resp_of = {30'd0, out_resp4};
        endcase
    endfunction

    function automatic logic [31:0] data_of(input int p);
        case (p)
            1:       data_of = out_data1;
            2:       data_of = out_data2;
            3:       data_of = out_data3;
            default: data_of = out_data4;
        endcase
    endfunction

    // One full request on port p; cmd 3 is driven during the op2 cycle to show it is ignored.
    task automatic do_op(input string tag, input int p, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed);
        @(negedge c_clk);
        cmd[p] = c;
        din[p] = a;
        @(negedge c_clk);
        check_val({tag, "_busy_resp"}, resp_of(p), 32'd0);
        cmd[p] = 4'd3;
        din[p] = b;
        @(negedge c_clk);
        check_val({tag, "_resp"}, resp_of(p), {30'd0, er});
        check_val({tag, "_data"}, data_of(p), ed);
        cmd[p] = 4'd0;
        din[p] = 32'd0;
        @(negedge c_clk);
        check_val({tag, "_after_resp"}, resp_of(p), 32'd0);
    endtask

    initial begin
        for (int i = 1; i <= 4; i++) begin
            cmd[i] = 4'd0;
            din[i] = 32'd0;
        end
        reset = 7'b1000000;
        repeat (4) @(negedge c_clk);
        reset = 7'b0000000;
        @(negedge c_clk);
        for (int i = 1; i <= 4; i++) begin
            check_val($sformatf("rst_resp%0d", i), resp_of(i), 32'd0);
            check_val($sformatf("rst_data%0d", i), data_of(i), 32'd0);
        end
        @(negedge c_clk);
        check_val("idle_resp1", resp_of(1), 32'd0);

        do_op("add1", 1, 4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000);
        do_op("add2", 1, 4'd1, 32'h1FFFFFFF, 32'h1FFFFFFF, 2'd1, 32'h3FFFFFFE);
        do_op("add0", 1, 4'd1, 32'h00000000, 32'h00000000, 2'd1, 32'h00000000);
        do_op("addmax", 2, 4'd1, 32'hFFFFFFFF, 32'h00000000, 2'd1, 32'hFFFFFFFF);
        do_op("addovf", 1, 4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000);
        do_op("subunf", 1, 4'd2, 32'h00000001, 32'h0000000F, 2'd2, 32'h00000000);
        do_op("sub", 1, 4'd2, 32'h0000000F, 32'h00000001, 2'd1, 32'h0000000E);
        do_op("subeq", 3, 4'd2, 32'h00000005, 32'h00000005, 2'd1, 32'h00000000);
        do_op("sll", 1, 4'd5, 32'h00000001, 32'h00000024, 2'd1, 32'h00000010);
        do_op("srl", 1, 4'd6, 32'h80000000, 32'h0000001F, 2'd1, 32'h00000001);
        do_op("srl_hi", 4, 4'd6, 32'hF0000000, 32'hFFFFFFE4, 2'd1, 32'h0F000000);

        // Invalid commands: one error per edge, no op2 phase.
        @(negedge c_clk);
        cmd[1] = 4'd3;
        din[1] = 32'd1;
        @(negedge c_clk);
        check_val("inv3_resp", resp_of(1), 32'd2);
        check_val("inv3_data", data_of(1), 32'd0);
        cmd[1] = 4'd4;
        @(negedge c_clk);
        check_val("inv4_resp", resp_of(1), 32'd2);
        check_val("inv4_data", data_of(1), 32'd0);
        cmd[1] = 4'd0;
        din[1] = 32'd0;
        @(negedge c_clk);
        check_val("inv_noop2", resp_of(1), 32'd0);
        do_op("after_inv", 1, 4'd1, 32'h00000002, 32'h00000003, 2'd1, 32'h00000005);

        // All four ports in the same cycle.
        @(negedge c_clk);
        cmd[1] = 4'd1; din[1] = 32'h00000001;
        cmd[2] = 4'd1; din[2] = 32'h00000010;
        cmd[3] = 4'd1; din[3] = 32'hFFFFFFFF;
        cmd[4] = 4'd1; din[4] = 32'h7FFFFFFF;
        @(negedge c_clk);
        for (int i = 1; i <= 4; i++) cmd[i] = 4'd0;
        din[1] = 32'h00000002;
        din[2] = 32'h00000020;
        din[3] = 32'h00000001;
        din[4] = 32'h80000000;
        @(negedge c_clk);
        check_val("cc_resp1", resp_of(1), 32'd1);
        check_val("cc_data1", data_of(1), 32'h00000003);
        check_val("cc_resp2", resp_of(2), 32'd1);
        check_val("cc_data2", data_of(2), 32'h00000030);
        check_val("cc_resp3", resp_of(3), 32'd2);
        check_val("cc_data3", data_of(3), 32'h00000000);
        check_val("cc_resp4", resp_of(4), 32'd1);
        check_val("cc_data4", data_of(4), 32'hFFFFFFFF);
        for (int i = 1; i <= 4; i++) din[i] = 32'd0;

        // Reset during the op2 cycle aborts the request.
        @(negedge c_clk);
        cmd[1] = 4'd1;
        din[1] = 32'h00000004;
        @(negedge c_clk);
        cmd[1] = 4'd0;
        din[1] = 32'h00000005;
        reset = 7'b0000001;
        @(negedge c_clk);
        check_val("abort_resp", resp_of(1), 32'd0);
        check_val("abort_data", data_of(1), 32'd0);
        reset = 7'b0000000;
        din[1] = 32'd0;
        @(negedge c_clk);
        check_val("abort_late", resp_of(1), 32'd0);
        do_op("post_abort", 1, 4'd1, 32'h00000004, 32'h00000005, 2'd1, 32'h00000009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
